// File: rtl/scan_index_gen.sv
// scan_index_gen: walks a 3-to-8 decoder select/enable through channels 0..last_idx with a programmable dwell.
// Define SCAN_BLANK_EN to insert a one-cycle en=0 blanking gap between consecutive channels.
module scan_index_gen #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [2:0]         last_idx,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         a,
  output logic               en,
  output logic               busy,
  output logic               step,
  output logic               done
);
`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif
  state_t             r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell;
  logic [2:0]         r_last;
  logic               r_cont;
  logic               r_stop_p;
  logic               w_dwell_done;
  logic               w_end;
  logic [2:0]         w_next;
  assign w_dwell_done = r_cnt == r_dwell - DWELL_W'(1);
  // a stop arriving on the completion cycle itself still ends the scan here
  assign w_end  = r_stop_p | stop | (a == r_last & ~r_cont);
  assign w_next = a == r_last ? 3'd0 : a + 3'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dwell  <= '0;
      r_last   <= '0;
      r_cont   <= 1'b0;
      r_stop_p <= 1'b0;
      a        <= '0;
      en       <= 1'b0;
      busy     <= 1'b0;
      step     <= 1'b0;
      done     <= 1'b0;
    end else begin
      step <= 1'b0;
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state  <= SCAN;
          r_dwell  <= dwell == '0 ? DWELL_W'(1) : dwell;
          r_last   <= last_idx;
          r_cont   <= continuous;
          r_cnt    <= '0;
          r_stop_p <= 1'b0;
          a        <= 3'd0;
          en       <= 1'b1;
          busy     <= 1'b1;
          step     <= 1'b1;
        end
        SCAN: if (!w_dwell_done) begin
          r_cnt    <= r_cnt + DWELL_W'(1);
          r_stop_p <= r_stop_p | stop;
        end else if (w_end) begin
          r_state  <= IDLE;
          r_stop_p <= 1'b0;
          a        <= 3'd0;
          en       <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
`ifdef SCAN_BLANK_EN
        else if (r_last != 3'd0) begin
          r_state <= GAP;
          en      <= 1'b0;
        end
`endif
        else begin
          a     <= w_next;
          r_cnt <= '0;
          step  <= 1'b1;
        end
`ifdef SCAN_BLANK_EN
        GAP: begin
          r_state  <= SCAN;
          r_stop_p <= r_stop_p | stop;
          r_cnt    <= '0;
          a        <= w_next;
          en       <= 1'b1;
          step     <= 1'b1;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_index_gen.sv
// tb_scan_index_gen: scoreboard bench; expected step/done events are queued at launch and matched by a monitor.
module tb_scan_index_gen;
  localparam int DW = 8;
`ifdef SCAN_BLANK_EN
  localparam int BLANK = 1;
`else
  localparam int BLANK = 0;
`endif
  logic          clk = 1'b0;
  logic          rst, start, stop, continuous;
  logic [2:0]    last_idx;
  logic [DW-1:0] dwell;
  logic [2:0]    a;
  logic          en, busy, step, done;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            en_cnt = 0;
  typedef struct {
    bit       is_done;
    logic [2:0] a;
    int       cyc;
    int       en_n;
  } ev_t;
  ev_t q[$];
  scan_index_gen #(.DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .last_idx(last_idx), .dwell(dwell), .a(a), .en(en), .busy(busy), .step(step), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (rst) en_cnt = 0;
    else begin
      if (en) en_cnt++;
      if (!busy) begin
        chk("idle_en", en, 0);
        chk("idle_a", a, 0);
      end
      if (step || done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: step=%0d done=%0d a=%0d at cycle %0d, none expected", step, done, a, cyc);
        end else begin
          e = q.pop_front();
          chk("ev_kind_done", done, e.is_done);
          chk("ev_cycle", cyc, e.cyc);
          chk("ev_a", a, e.is_done ? 0 : e.a);
          chk("ev_busy", busy, !e.is_done);
          chk("ev_en", en, !e.is_done);
          if (e.is_done) begin
            chk("en_cycles", en_cnt, e.en_n);
            en_cnt = 0;
          end
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_scan(int t0, int d, int l, int nch, bit with_done);
    int g = (BLANK != 0 && l != 0) ? 1 : 0;
    int s = t0;
    for (int k = 0; k < nch; k++) begin
      s = t0 + 1 + k * (d + g);
      q.push_back(ev_t'{1'b0, 3'(k % (l + 1)), s, 0});
    end
    if (with_done) q.push_back(ev_t'{1'b1, 3'd0, s + d, nch * d});
  endtask
  task automatic launch(bit c, int l, int dw, int nch, bit with_done, output int t0);
    start      = 1'b1;
    continuous = c;
    last_idx   = 3'(l);
    dwell      = DW'(dw);
    t0         = cyc;
    push_scan(t0, dw == 0 ? 1 : dw, l, nch, with_done);
    tick();
    start      = 1'b0;
    continuous = ~c;
    last_idx   = 3'd7;
    dwell      = DW'(5);
  endtask
  task automatic wait_done(string nm, int limit);
    int n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    chk(nm, done, 1);
  endtask
  task automatic pulse_stop_at(int c);
    while (cyc < c) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
  initial begin
    int t;
    int g;
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; last_idx = '0; dwell = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_a", a, 0);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);
    chk("rst_done", done, 0);
    for (int i = 0; i < 5; i++) begin
      stop = (i == 2);
      tick();
    end
    stop = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    g = BLANK;
    stop = 1'b1;
    launch(0, 7, 3, 8, 1, t);
    stop = 1'b0;
    wait_done("single_pass_done", 60);
    launch(1, 2, 2, 5, 1, t);
    pulse_stop_at(t + 1 + 4 * (2 + g));
    wait_done("cont_stop_done", 40);
    tick();
    launch(0, 1, 0, 2, 1, t);
    start = 1'b1; last_idx = 3'd7; dwell = DW'(5); continuous = 1'b1;
    tick();
    start = 1'b0;
    wait_done("dwell0_done", 20);
    tick();
    launch(1, 0, 2, 3, 1, t);
    pulse_stop_at(t + 1 + 2 * 2);
    wait_done("single_ch_done", 30);
    launch(1, 1, 2, 4, 1, t);
    pulse_stop_at(t + 1 + 3 * (2 + g));
    wait_done("blank_cont_done", 40);
    tick();
    launch(1, 7, 3, 5, 0, t);
    while (cyc < t + 2 + 4 * (3 + g)) tick();
    chk("pre_rst_a", a, 4);
    rst = 1'b1;
    tick();
    chk("mid_rst_a", a, 0);
    chk("mid_rst_en", en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_step", step, 0);
    chk("mid_rst_done", done, 0);
    rst = 1'b0;
    chk("rst_flush", q.size(), 0);
    repeat (4) tick();
    launch(0, 1, 1, 2, 1, t);
    wait_done("restart_done", 20);
    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
